// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART receiver.
// Holds state encodings, frame constants and the bit-period helper.
package uart_pkg;

  localparam logic [2:0] StIdleEnc     = 3'd0;
  localparam logic [2:0] StStartEnc    = 3'd1;
  localparam logic [2:0] StDataEnc     = 3'd2;
  localparam logic [2:0] StStopEnc     = 3'd3;
  localparam logic [2:0] StWaitIdleEnc = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = StIdleEnc,
    StStart    = StStartEnc,
    StData     = StDataEnc,
    StStop     = StStopEnc,
    StWaitIdle = StWaitIdleEnc
  } rx_state_e;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  // Rounded-to-nearest clock cycles per serial bit.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready read port of the UART receive FIFO.
// The receiver drives it as master; the consumer attaches as slave.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DataBits-1:0] rdata;
  logic                rvalid;
  logic                rready;

  modport master (
    output rdata,
    output rvalid,
    input  rready
  );

  modport slave (
    input  rdata,
    input  rvalid,
    output rready
  );

endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
// Accepts a push into a full FIFO when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  // Memory is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, bit-centre sampling FSM and receive FIFO.
// Completed bytes are read through the valid/ready interface.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned BUF_DEPTH = 256
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overflow
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD_RATE);
  localparam int unsigned Half       = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);

  if (ClksPerBit < 4) begin : gen_bad_baud
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if ((BUF_DEPTH < 2) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0)) begin : gen_bad_depth
    $error("uart_rx: BUF_DEPTH must be a power of two and at least 2");
  end

  localparam logic [CntW-1:0] HalfLoad = CntW'(Half - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(ClksPerBit - 1);
  localparam logic [2:0]      LastBit  = 3'(DataBits - 1);

  logic                rx_meta_q;
  logic                rxs_q;
  rx_state_e           state_q;
  logic [CntW-1:0]     cnt_q;
  logic [2:0]          bit_idx_q;
  logic [DataBits-1:0] data_q;

  logic cnt_done;
  logic stop_sample;
  logic byte_push;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign cnt_done    = (cnt_q == '0);
  assign stop_sample = (state_q == StStop) && cnt_done;
  assign byte_push   = stop_sample && rxs_q;
  assign pop         = !fifo_empty && bus.rready;
  assign bus.rvalid  = !fifo_empty;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (byte_push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            cnt_q   <= HalfLoad;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (!cnt_done) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rxs_q) begin
            cnt_q     <= BitLoad;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            state_q <= StIdle;
          end
        end
        StData: begin
          if (!cnt_done) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            data_q[bit_idx_q] <= rxs_q;
            cnt_q             <= BitLoad;
            bit_idx_q         <= bit_idx_q + 1'b1;
            if (bit_idx_q == LastBit) begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (!cnt_done) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rxs_q) begin
            state_q <= StIdle;
          end else begin
            frame_err <= 1'b1;
            state_q   <= StWaitIdle;
          end
        end
        StWaitIdle: begin
          if (rxs_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DataBits),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (byte_push),
    .wdata (data_q),
    .pop   (bus.rready),
    .rdata (bus.rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 10 clocks per bit with a 256-entry FIFO.
// Popped bytes are compared against a queue of expected bytes.
module tb_uart_rx;

  localparam int unsigned ClkHz = 1_152_000;
  localparam int unsigned Baud  = 115_200;
  localparam int unsigned Depth = 256;
  localparam int          Cpb   = 10;   // (1152000 + 57600) / 115200
  localparam int          Half  = 5;
  localparam int          LatNom = 2 + Half + 9 * Cpb;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_pops;
    int         exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic frame_err;
  logic overflow;

  uart_rx_if bus ();

  uart_rx #(
    .CLK_HZ    (ClkHz),
    .BAUD_RATE (Baud),
    .BUF_DEPTH (Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .bus       (bus),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1000;
  int pops = 0;
  int fe_pulses = 0;
  int fe_run = 0;
  int fe_max_run = 0;
  int rv_run = 0;
  int rv_max_run = 0;
  logic rv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  // One 8N1 frame; a nonzero gap releases the line high for gap cycles afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
    tick();
    rx = 1'b0;
    start_cyc = cyc;
    repeat (Cpb - 1) tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      rx = b[i];
      repeat (Cpb - 1) tick();
    end
    tick();
    rx = stop;
    repeat (Cpb - 1) tick();
    if (gap > 0) begin
      tick();
      rx = 1'b1;
      repeat (gap - 1) tick();
    end
  endtask

  initial begin : monitor
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rvalid && bus.rready) begin
          checks++;
          pops++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected got=%02h want=none", bus.rdata);
          end else begin
            want = exp_q.pop_front();
            if (bus.rdata !== want) begin
              errors++;
              $display("FAIL pop_data got=%02h want=%02h", bus.rdata, want);
            end
          end
        end
        if (frame_err && !fe_prev) fe_pulses++;
        fe_run = frame_err ? fe_run + 1 : 0;
        if (fe_run > fe_max_run) fe_max_run = fe_run;
        if (bus.rvalid && !rv_prev) rise_cyc = cyc;
        rv_run = bus.rvalid ? rv_run + 1 : 0;
        if (rv_run > rv_max_run) rv_max_run = rv_run;
      end
      rv_prev = bus.rvalid;
      fe_prev = frame_err;
    end
  end

  initial begin : watchdog
    #1_600_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    vec_t vecs [7];
    int p0;
    int f0;
    int lat;
    int n;

    vecs[0] = '{8'h55, 1'b1, 2, 1, 0};
    vecs[1] = '{8'hA5, 1'b0, 3, 0, 1};
    vecs[2] = '{8'h3C, 1'b1, 2, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 2, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 2, 1, 0};
    vecs[5] = '{8'h96, 1'b0, 1, 0, 1};
    vecs[6] = '{8'h96, 1'b1, 2, 1, 0};

    rst = 1'b1;
    rx = 1'b1;
    bus.rready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_rvalid", bus.rvalid, 1'b0);
    check("rst_rdata", bus.rdata, 8'h00);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // First byte with the consumer stalled: latency and head data.
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 2);
    @(negedge clk);
    check("lat_rvalid", bus.rvalid, 1'b1);
    check("lat_rdata", bus.rdata, 8'h55);
    check("lat_no_ferr", fe_pulses, 0);
    lat = rise_cyc - start_cyc;
    checks++;
    if (lat < LatNom - 1 || lat > LatNom + 1) begin
      errors++;
      $display("FAIL latency got=%0d want=%0d+-1", lat, LatNom);
    end
    tick();
    bus.rready = 1'b1;
    repeat (3) tick();
    check("lat_popped", pops, 1);

    // Short low glitch must not start a frame.
    p0 = pops;
    f0 = fe_pulses;
    tick();
    rx = 1'b0;
    repeat (2) tick();
    tick();
    rx = 1'b1;
    repeat (30) tick();
    check("glitch_no_pop", pops, p0);
    check("glitch_no_ferr", fe_pulses, f0);
    check("glitch_rvalid", bus.rvalid, 1'b0);
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, 2);
    repeat (3) tick();
    check("glitch_then_a3", pops, p0 + 1);

    // Bad stop bit with the consumer stalled.
    bus.rready = 1'b0;
    f0 = fe_pulses;
    send_frame(8'hA5, 1'b0, 3);
    repeat (3) tick();
    check("ferr_rvalid", bus.rvalid, 1'b0);
    check("ferr_pulse", fe_pulses, f0 + 1);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 2);
    @(negedge clk);
    check("ferr_then_rvalid", bus.rvalid, 1'b1);
    check("ferr_then_rdata", bus.rdata, 8'h3C);
    tick();
    bus.rready = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 7; v++) begin
      p0 = pops;
      f0 = fe_pulses;
      if (vecs[v].stop) exp_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].gap);
      repeat (4) tick();
      check($sformatf("vec%0d_pops", v), pops - p0, vecs[v].exp_pops);
      check($sformatf("vec%0d_ferr", v), fe_pulses - f0, vecs[v].exp_ferr);
    end
    check("ferr_one_cycle", fe_max_run, 1);

    // Back-to-back frames with no idle time, consumer always ready.
    rv_max_run = 0;
    p0 = pops;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 2);
    repeat (3) tick();
    check("b2b_pops", pops - p0, 3);
    check("b2b_one_cycle", rv_max_run, 1);

    // Fill the FIFO, then one extra byte is dropped.
    bus.rready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0);
    end
    repeat (2) tick();
    check("full_no_overflow", overflow, 1'b0);
    check("full_rvalid", bus.rvalid, 1'b1);
    send_frame(8'h00, 1'b1, 2);
    repeat (2) tick();
    check("overflow_set", overflow, 1'b1);
    check("overflow_head", bus.rdata, 8'h00);
    bus.rready = 1'b1;
    n = 0;
    while (bus.rvalid && n < 400) begin
      tick();
      n++;
    end
    check("drain_rvalid", bus.rvalid, 1'b0);
    check("drain_count", pops - p0, 256);
    check("drain_queue", exp_q.size(), 0);
    check("overflow_sticky", overflow, 1'b1);

    // Reset during bit 4 with a byte pending in the FIFO.
    tick();
    bus.rready = 1'b0;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 2);
    @(negedge clk);
    check("pre_rst_rvalid", bus.rvalid, 1'b1);
    f0 = fe_pulses;
    tick();
    rx = 1'b0;
    repeat (Cpb - 1) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      rx = (i < 4) ? 1'b1 : 1'b0;
      repeat (Cpb - 1) tick();
    end
    tick();
    rst = 1'b1;
    rx = 1'b1;
    exp_q.delete();
    tick();
    @(negedge clk);
    check("midrst_rvalid", bus.rvalid, 1'b0);
    check("midrst_rdata", bus.rdata, 8'h00);
    check("midrst_frame_err", frame_err, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    check("postrst_idle", bus.rvalid, 1'b0);
    check("postrst_no_ferr", fe_pulses, f0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 2);
    @(negedge clk);
    check("postrst_rvalid", bus.rvalid, 1'b1);
    check("postrst_rdata", bus.rdata, 8'h81);
    p0 = pops;
    tick();
    bus.rready = 1'b1;
    repeat (3) tick();
    check("postrst_pop", pops - p0, 1);
    check("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
